// File: rtl/apu_dma_pkg.sv
// Shared types and constants for the 2A03 DMA arbiter: state encoding, cycle parity, default addresses.
package apu_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        SPR_RD,
        SPR_WR,
        DMC_RD
    } dma_state_e;

    localparam logic GET = 1'b0;
    localparam logic PUT = 1'b1;

    localparam logic [15:0] OAM_DMA_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] SPR_DEST_ADDR_DEF = 16'h2004;
    localparam int          SPR_LEN_DEF       = 256;

endpackage

// File: rtl/apu_dma_bus_mux.sv
// Picks who drives the CPU bus this cycle: the 6502 core, or the DMA engine in one of its bus states.
module apu_dma_bus_mux
    import apu_dma_pkg::*;
#(
    parameter logic [15:0] SPR_DEST_ADDR = SPR_DEST_ADDR_DEF
) (
    input  dma_state_e  state,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_rnw,
    input  logic [15:0] spr_addr,
    input  logic [15:0] dmc_addr,
    input  logic [7:0]  spr_byte,
    output logic [15:0] a_out,
    output logic [7:0]  d_out,
    output logic        rnw_out
);

    always_comb begin
        a_out   = cpu_a;
        d_out   = cpu_do;
        rnw_out = cpu_rnw;
        case (state)
            SPR_RD: begin
                a_out   = spr_addr;
                rnw_out = 1'b1;
            end
            SPR_WR: begin
                a_out   = SPR_DEST_ADDR;
                d_out   = spr_byte;
                rnw_out = 1'b0;
            end
            DMC_RD: begin
                a_out   = dmc_addr;
                rnw_out = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/apu_dma_arbiter.sv
// 2A03 bus arbiter: halts the 6502 for sprite (OAM) DMA and DPCM fetches, on GET/PUT cycle parity.
// Define APU_DMA_STATS_EN to add the STOLEN_CNT halted-cycle counter output.
module apu_dma_arbiter
    import apu_dma_pkg::*;
#(
    parameter logic [15:0] OAM_DMA_ADDR  = OAM_DMA_ADDR_DEF,
    parameter logic [15:0] SPR_DEST_ADDR = SPR_DEST_ADDR_DEF,
    parameter int          SPR_LEN       = SPR_LEN_DEF
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_RnW,
    input  logic [7:0]  DIN,
    input  logic        DMC_REQ,
    input  logic [15:0] DMC_ADDR,
    output logic        RDY,
    output logic [15:0] A_OUT,
    output logic [7:0]  D_OUT,
    output logic        RnW_OUT,
    output logic        DMC_ACK,
    output logic [7:0]  DMC_DATA,
    output logic        SPR_BUSY
`ifdef APU_DMA_STATS_EN
    ,
    output logic [15:0] STOLEN_CNT
`endif
);

    dma_state_e state;
    logic       parity;
    logic       dmc_pend;
    logic [7:0] page;
    logic [7:0] spr_byte;
    logic [8:0] count;
    logic       core_owns;
    logic       oam_trig;
    logic       dmc_set;
    logic       last_byte;

    // SPR_BUSY doubles as the sprite pending flag: set on the $4014 write, cleared after the last byte.
    assign core_owns = (state == IDLE) || (state == HALT);
    assign oam_trig  = core_owns && !CPU_RnW && (CPU_A == OAM_DMA_ADDR) && !SPR_BUSY;
    // REQ is still high during the ACK cycle; don't let it re-arm a second fetch.
    assign dmc_set   = DMC_REQ && !DMC_ACK;
    assign last_byte = (count == 9'(SPR_LEN - 1));

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= IDLE;
            parity   <= GET;
            page     <= '0;
            count    <= '0;
            spr_byte <= '0;
            dmc_pend <= 1'b0;
            RDY      <= 1'b1;
            SPR_BUSY <= 1'b0;
            DMC_ACK  <= 1'b0;
            DMC_DATA <= '0;
        end else if (CE) begin
            parity  <= ~parity;
            DMC_ACK <= 1'b0;
            if (oam_trig) begin
                page     <= CPU_DO;
                count    <= '0;
                SPR_BUSY <= 1'b1;
            end
            if (dmc_set)
                dmc_pend <= 1'b1;
            case (state)
                IDLE: if (SPR_BUSY || dmc_pend) begin
                    state <= HALT;
                    RDY   <= 1'b0;
                end
                // Sprite DMA may start on the very next GET; a DPCM fetch always spends one dummy cycle first.
                HALT: if (CPU_RnW) begin
                    if (parity == PUT && SPR_BUSY)
                        state <= dmc_pend ? DMC_RD : SPR_RD;
                    else
                        state <= ALIGN;
                end
                ALIGN: if (parity == PUT)
                    state <= dmc_pend ? DMC_RD : SPR_RD;
                SPR_RD: begin
                    spr_byte <= DIN;
                    state    <= SPR_WR;
                end
                SPR_WR: begin
                    count <= count + 9'd1;
                    if (last_byte)
                        SPR_BUSY <= 1'b0;
                    if (dmc_pend)
                        state <= DMC_RD;
                    else if (!last_byte)
                        state <= SPR_RD;
                    else begin
                        state <= IDLE;
                        RDY   <= 1'b1;
                    end
                end
                DMC_RD: begin
                    DMC_DATA <= DIN;
                    DMC_ACK  <= 1'b1;
                    dmc_pend <= 1'b0;
                    if (SPR_BUSY)
                        state <= ALIGN;
                    else begin
                        state <= IDLE;
                        RDY   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APU_DMA_STATS_EN
    always_ff @(posedge CLK) begin
        if (RES)
            STOLEN_CNT <= '0;
        else if (CE && !RDY && STOLEN_CNT != 16'hFFFF)
            STOLEN_CNT <= STOLEN_CNT + 16'd1;
    end
`endif

    apu_dma_bus_mux #(.SPR_DEST_ADDR(SPR_DEST_ADDR)) u_mux (
        .state    (state),
        .cpu_a    (CPU_A),
        .cpu_do   (CPU_DO),
        .cpu_rnw  (CPU_RnW),
        .spr_addr ({page, count[7:0]}),
        .dmc_addr (DMC_ADDR),
        .spr_byte (spr_byte),
        .a_out    (A_OUT),
        .d_out    (D_OUT),
        .rnw_out  (RnW_OUT)
    );

endmodule

// File: tb/tb_apu_dma_arbiter.sv
// Scoreboard bench for apu_dma_arbiter: sprite DMA, DPCM fetch, halt cycle counts and reset.
module tb_apu_dma_arbiter;

    localparam logic GET = 1'b0;
    localparam logic PUT = 1'b1;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        CE = 1'b0;
    logic [15:0] CPU_A = 16'h8000;
    logic [7:0]  CPU_DO = 8'h00;
    logic        CPU_RnW = 1'b1;
    logic [7:0]  DIN = 8'h00;
    logic        DMC_REQ = 1'b0;
    logic [15:0] DMC_ADDR = 16'hC000;
    logic        RDY, RnW_OUT, DMC_ACK, SPR_BUSY;
    logic [15:0] A_OUT;
    logic [7:0]  D_OUT, DMC_DATA;
`ifdef APU_DMA_STATS_EN
    logic [15:0] STOLEN_CNT;
`endif

    apu_dma_arbiter dut (
        .CLK(CLK), .RES(RES), .CE(CE), .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_RnW(CPU_RnW),
        .DIN(DIN), .DMC_REQ(DMC_REQ), .DMC_ADDR(DMC_ADDR), .RDY(RDY), .A_OUT(A_OUT),
        .D_OUT(D_OUT), .RnW_OUT(RnW_OUT), .DMC_ACK(DMC_ACK), .DMC_DATA(DMC_DATA),
        .SPR_BUSY(SPR_BUSY)
`ifdef APU_DMA_STATS_EN
        , .STOLEN_CNT(STOLEN_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_err = 0;
    int n_low, tot_low, n_wr, n_ack, arm_at, exp_wr_at_dmc;
    logic par;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  dmc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [15:0] a);
        return (a == 16'hC000) ? 8'h5A : (a[15:8] ^ a[7:0] ^ 8'h3C);
    endfunction

    // Observe the current CPU cycle just before its CE edge, and answer reads from the memory model.
    task automatic mon();
        if (!RDY) begin
            n_low++;
            tot_low++;
        end
        if (DMC_ACK) begin
            n_ack++;
            if (dmc_q.size() == 0) chk("dmc_ack_unexp", DMC_ACK, 0);
            else                   chk("dmc_data", DMC_DATA, dmc_q.pop_front());
            DMC_REQ = 1'b0;
        end
        if (!RnW_OUT && A_OUT == 16'h2004) begin
            chk("spr_wr_par", par, PUT);
            if (wr_q.size() == 0) chk("spr_wr_unexp", RnW_OUT, 1);
            else                  chk("spr_wr_data", D_OUT, wr_q.pop_front());
            n_wr++;
        end
        if (!RDY && RnW_OUT && A_OUT != CPU_A && A_OUT == DMC_ADDR) begin
            chk("dmc_rd_par", par, GET);
            if (exp_wr_at_dmc >= 0) chk("dmc_after_wr", n_wr, exp_wr_at_dmc);
        end else if (!RDY && RnW_OUT && A_OUT != CPU_A) begin
            chk("spr_rd_par", par, GET);
            if (rd_q.size() == 0) chk("spr_rd_unexp", A_OUT, CPU_A);
            else                  chk("spr_rd_addr", A_OUT, rd_q.pop_front());
            if (arm_at >= 0 && A_OUT[7:0] == 8'(arm_at)) begin
                DMC_REQ = 1'b1;
                dmc_q.push_back(8'h5A);
                arm_at = -1;
            end
        end
        DIN = mem(A_OUT);
    endtask

    // One CPU cycle: a non-CE edge, then the CE edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        mon();
        CE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        CE = 1'b0;
        if (!RES) par = ~par;
    endtask

    task automatic idle_to(input logic p);
        CPU_A = 16'h8000;
        CPU_RnW = 1'b1;
        if (par != p) step();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            step();
            if (n_low > 0 && RDY) break;
        end
        chk({tag, "_done"}, RDY, 1);
    endtask

    task automatic chk_stats(input string tag);
`ifdef APU_DMA_STATS_EN
        chk({tag, "_stolen"}, STOLEN_CNT, tot_low);
`endif
    endtask

    task automatic spr_test(input string tag, input logic [7:0] pg, input logic p,
                            input int nwr, input int dmc_at);
        int h, exp_low;
        logic hp;
        idle_to(p);
        for (int i = 0; i < 256; i++) begin
            rd_q.push_back({pg, 8'(i)});
            wr_q.push_back(mem({pg, 8'(i)}));
        end
        n_low = 0; n_wr = 0; n_ack = 0;
        arm_at = dmc_at;
        exp_wr_at_dmc = (dmc_at < 0) ? -1 : dmc_at + 1;
        CPU_A = 16'h4014; CPU_RnW = 1'b0; CPU_DO = pg;
        step();
        CPU_A = 16'h0300; CPU_DO = 8'h77;
        for (int i = 0; i < nwr; i++) begin
            #1;
            chk({tag, "_wr_a"}, A_OUT, 16'h0300);
            chk({tag, "_wr_rnw"}, RnW_OUT, 0);
            chk({tag, "_wr_d"}, D_OUT, 8'h77);
            step();
        end
        CPU_A = 16'h8000; CPU_RnW = 1'b1;
        // Halt read lands 2 cycles after the $4014 write, or on the first read after trailing writes.
        h = (nwr > 1) ? 1 + nwr : 2;
        hp = p ^ h[0];
        exp_low = (h - 2) + ((hp == GET) ? 514 : 513) + ((dmc_at >= 0) ? 2 : 0);
        wait_done(tag);
        step();
        chk({tag, "_low"}, n_low, exp_low);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
        chk({tag, "_wr_left"}, wr_q.size(), 0);
        chk({tag, "_busy"}, SPR_BUSY, 0);
        chk({tag, "_acks"}, n_ack, (dmc_at >= 0) ? 1 : 0);
        chk_stats(tag);
    endtask

    task automatic dmc_test(input string tag, input logic p);
        idle_to(p);
        n_low = 0; n_ack = 0; exp_wr_at_dmc = -1;
        DMC_REQ = 1'b1;
        dmc_q.push_back(8'h5A);
        step();
        wait_done(tag);
        step();
        chk({tag, "_low"}, n_low, (p == GET) ? 3 : 4);
        chk({tag, "_acks"}, n_ack, 1);
        chk({tag, "_left"}, dmc_q.size(), 0);
        chk_stats(tag);
    endtask

    initial begin
        par = GET; tot_low = 0; n_low = 0; n_wr = 0; n_ack = 0; arm_at = -1; exp_wr_at_dmc = -1;
        RES = 1'b1;
        CPU_A = 16'h1234; CPU_DO = 8'hAB; CPU_RnW = 1'b0;
        for (int i = 0; i < 100; i++) step();
        #1;
        chk("rst_rdy", RDY, 1);
        chk("rst_busy", SPR_BUSY, 0);
        chk("rst_ack", DMC_ACK, 0);
        chk("rst_dmc_data", DMC_DATA, 0);
        chk("rst_a", A_OUT, 16'h1234);
        chk("rst_d", D_OUT, 8'hAB);
        chk("rst_rnw", RnW_OUT, 0);
        @(negedge CLK);
        RES = 1'b0; par = GET; tot_low = 0;
        CPU_A = 16'h8000; CPU_RnW = 1'b1;

        spr_test("spr_get", 8'h02, GET, 0, -1);
        spr_test("spr_put", 8'h03, PUT, 0, -1);
        spr_test("spr_wrs", 8'h06, PUT, 3, -1);
        dmc_test("dmc_get", GET);
        dmc_test("dmc_put", PUT);
        spr_test("spr_dmc", 8'h04, GET, 0, 100);

        // Reset in the middle of a sprite DMA, after 40 bytes have been written.
        idle_to(GET);
        for (int i = 0; i < 256; i++) begin
            rd_q.push_back({8'h05, 8'(i)});
            wr_q.push_back(mem({8'h05, 8'(i)}));
        end
        n_wr = 0; exp_wr_at_dmc = -1;
        CPU_A = 16'h4014; CPU_RnW = 1'b0; CPU_DO = 8'h05;
        step();
        CPU_A = 16'h8000; CPU_RnW = 1'b1;
        for (int i = 0; i < 200 && n_wr < 40; i++) step();
        chk("mid_wr_cnt", n_wr, 40);
        chk("mid_rdy_low", RDY, 0);
        RES = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid_rst_rdy", RDY, 1);
        chk("mid_rst_busy", SPR_BUSY, 0);
        chk("mid_rst_dmc_data", DMC_DATA, 0);
        chk("mid_rst_a", A_OUT, CPU_A);
        chk("mid_rst_rnw", RnW_OUT, CPU_RnW);
`ifdef APU_DMA_STATS_EN
        chk("mid_rst_stolen", STOLEN_CNT, 0);
`endif
        @(negedge CLK);
        RES = 1'b0; par = GET; tot_low = 0;
        rd_q.delete(); wr_q.delete();
        n_low = 0; n_wr = 0;
        for (int i = 0; i < 10; i++) step();
        chk("post_rst_low", n_low, 0);
        chk("post_rst_wr", n_wr, 0);
        chk("post_rst_rdy", RDY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
